alu_bist: RTL

ALU_BIST -- requirements
Module: alu_bist

---
 rtl/alu_bist_pkg.sv | 45 ++++
 rtl/alu_bist_if.sv | 15 +
 rtl/alu_bist_vmem.sv | 26 ++
 rtl/alu_bist.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU BIST block: FSM states, ALU opcodes,
// and the bit layout of one stored test vector {A, B, ALUOp, Result_exp, Flag_exp, last}.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int OP_W = 5;
    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b01000;

    // Offsets are LSB positions; 'last' sits in bit 0, A occupies the MSBs.
    function automatic int vec_w(input int w);
        return 3 * w + 7;
    endfunction

    function automatic int last_off(input int w);
        return 0 * w;
    endfunction

    function automatic int flag_off(input int w);
        return 0 * w + 1;
    endfunction

    function automatic int res_off(input int w);
        return 0 * w + 2;
    endfunction

    function automatic int op_off(input int w);
        return w + 2;
    endfunction

    function automatic int b_off(input int w);
        return w + 2 + OP_W;
    endfunction

    function automatic int a_off(input int w);
        return 2 * w + 2 + OP_W;
    endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/result bus between the BIST sequencer (master) and the ALU under test (slave).
interface alu_bist_if
    import alu_bist_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OP_W-1:0]  ALUOp;
    logic [WIDTH-1:0] Result;
    logic             Flag;

    modport master (output A, output B, output ALUOp, input Result, input Flag);
    modport slave  (input A, input B, input ALUOp, output Result, output Flag);
endinterface

// File: rtl/alu_bist_vmem.sv
// Test-vector store: one write port, one registered read port (data valid the cycle
// after re). The array is deliberately not reset so vectors survive a run abort.
module alu_bist_vmem #(
    parameter int DW    = 103,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/alu_bist.sv
// ALU BIST sequencer: replays stored vectors into the ALU, one per ALU_LAT+2 cycles,
// and counts mismatches. start and load_en are ignored while a run is in progress.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int DEPTH       = 64,
    parameter  int ALU_LAT     = 0,
    parameter  int STOP_ON_ERR = 0,
    localparam int AW          = $clog2(DEPTH),
    localparam int VW          = vec_w(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [VW-1:0] load_data,
    alu_bist_if.master    alu,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic          err_valid,
    output logic [AW-1:0] err_idx
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_DRIVE = ST_DRIVE;
    localparam logic [1:0] S_DONE  = ST_DONE;

    localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    logic [1:0]       state;
    logic [AW-1:0]    idx;
    logic [LW-1:0]    lat_cnt;
    logic [VW-1:0]    vec;

    logic [WIDTH-1:0] vec_a;
    logic [WIDTH-1:0] vec_b;
    logic [OP_W-1:0]  vec_op;
    logic [WIDTH-1:0] vec_res;
    logic             vec_flag;
    logic             vec_last;
    logic             mismatch;
    logic             drive_end;
    logic             run_end;

    assign vec_a    = vec[a_off(WIDTH)   +: WIDTH];
    assign vec_b    = vec[b_off(WIDTH)   +: WIDTH];
    assign vec_op   = vec[op_off(WIDTH)  +: OP_W];
    assign vec_res  = vec[res_off(WIDTH) +: WIDTH];
    assign vec_flag = vec[flag_off(WIDTH)];
    assign vec_last = vec[last_off(WIDTH)];

    // The read register is only reloaded in READ, so operands hold for all of DRIVE.
    alu_bist_vmem #(
        .DW    (VW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_vmem (
        .clock (clock),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state == S_READ),
        .raddr (idx),
        .rdata (vec)
    );

    assign busy = (state == S_READ) || (state == S_DRIVE);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    assign alu.A     = (state == S_DRIVE) ? vec_a  : '0;
    assign alu.B     = (state == S_DRIVE) ? vec_b  : '0;
    assign alu.ALUOp = (state == S_DRIVE) ? vec_op : '0;

    assign mismatch  = (alu.Result != vec_res) || (alu.Flag != vec_flag);
    assign drive_end = (state == S_DRIVE) && (lat_cnt == LW'(ALU_LAT));
    assign run_end   = vec_last || (idx == AW'(DEPTH - 1)) || ((STOP_ON_ERR != 0) && mismatch);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            lat_cnt   <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            err_idx   <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_READ;
                        idx       <= '0;
                        err_count <= '0;
                    end
                end
                S_READ: begin
                    state   <= S_DRIVE;
                    lat_cnt <= '0;
                end
                S_DRIVE: begin
                    if (drive_end) begin
                        if (mismatch) begin
                            err_count <= err_count + 1'b1;
                            err_valid <= 1'b1;
                            err_idx   <= idx;
                        end
                        if (run_end) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_READ;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
